// File: rtl/dm_select_scheduler.sv
// Frame-based digital-mic select scheduler: fixed, round-robin, or auto
// loudest-mic selection driving DesiredDM into the mic interface and FFT path.
module dm_select_scheduler #(
    parameter int FRAME_LEN   = 512,
    parameter int SETTLE      = 16,
    parameter int HOLD_FRAMES = 32
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        SampleDelayZero,
    input  logic [8:0]  DesiredDMInterfaceOutput,
    input  logic [1:0]  mode,
    input  logic [1:0]  fixed_sel,
    output logic [1:0]  DesiredDM,
    output logic        sel_changed,
    output logic        scan_active,
    output logic [17:0] best_energy
);

    localparam int FC_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam logic [FC_W-1:0] FC_LAST   = FC_W'(FRAME_LEN - 1);
    localparam logic [FC_W-1:0] FC_SETTLE = FC_W'(SETTLE);
    localparam logic [7:0]      HOLD_LAST = 8'(HOLD_FRAMES);

    typedef enum logic [2:0] {
        ST_FIXED,
        ST_RR,
        ST_SCAN,
        ST_DECIDE,
        ST_HOLD
    } state_t;

    state_t          state_q, state_d;
    logic [FC_W-1:0] fc_q, fc_d;
    logic [17:0]     acc_q, acc_d;
    logic [17:0]     e_q [4];
    logic [17:0]     e_d [4];
    logic [1:0]      scan_k_q, scan_k_d;
    logic [7:0]      hold_q, hold_d;
    logic [1:0]      dm_q, dm_d;
    logic            sel_changed_q;
    logic            scan_active_q, scan_active_d;
    logic [17:0]     best_energy_q, best_energy_d;

    logic            fe;
    logic            mode_auto;
    logic            mode_rr;
    logic [8:0]      mag;
    logic [18:0]     acc_sum;
    logic [17:0]     acc_add;
    logic [7:0]      hold_inc;
    logic [1:0]      best_idx;
    logic [17:0]     best_val;

    always_comb begin
        fe        = SampleDelayZero && (fc_q == FC_LAST);
        mode_auto = (mode == 2'b10);
        mode_rr   = (mode == 2'b01);
        // Magnitude fits 9 bits unsigned, so |-256| = 256 needs no special case.
        mag       = DesiredDMInterfaceOutput[8] ? (~DesiredDMInterfaceOutput + 9'd1)
                                                : DesiredDMInterfaceOutput;
        acc_sum   = {1'b0, acc_q} + {10'd0, mag};
        acc_add   = acc_sum[18] ? 18'h3FFFF : acc_sum[17:0];
        hold_inc  = hold_q + 8'd1;

        best_idx = 2'd0;
        best_val = e_q[0];
        for (int i = 1; i < 4; i++) begin
            if (e_q[i] > best_val) begin
                best_val = e_q[i];
                best_idx = 2'(i);
            end
        end

        state_d       = state_q;
        fc_d          = fc_q;
        acc_d         = acc_q;
        e_d           = e_q;
        scan_k_d      = scan_k_q;
        hold_d        = hold_q;
        dm_d          = dm_q;
        scan_active_d = scan_active_q;
        best_energy_d = best_energy_q;

        if (SampleDelayZero) begin
            fc_d = fe ? '0 : fc_q + FC_W'(1);
        end

        // The FE strobe of a scan frame is accumulated before e[k] is captured.
        if (state_q == ST_SCAN && SampleDelayZero && fc_q >= FC_SETTLE) begin
            acc_d = acc_add;
        end

        if (state_q == ST_DECIDE) begin
            dm_d          = best_idx;
            best_energy_d = best_val;
            hold_d        = 8'd0;
            state_d       = ST_HOLD;
        end else if (fe) begin
            if (mode_auto) begin
                case (state_q)
                    ST_SCAN: begin
                        e_d[scan_k_q] = acc_d;
                        acc_d         = '0;
                        if (scan_k_q == 2'd3) begin
                            state_d       = ST_DECIDE;
                            scan_active_d = 1'b0;
                        end else begin
                            scan_k_d = scan_k_q + 2'd1;
                            dm_d     = scan_k_q + 2'd1;
                        end
                    end
                    ST_HOLD: begin
                        hold_d = hold_inc;
                        if (hold_inc == HOLD_LAST) begin
                            state_d       = ST_SCAN;
                            scan_k_d      = 2'd0;
                            dm_d          = 2'd0;
                            acc_d         = '0;
                            scan_active_d = 1'b1;
                        end
                    end
                    default: begin
                        state_d       = ST_SCAN;
                        scan_k_d      = 2'd0;
                        dm_d          = 2'd0;
                        acc_d         = '0;
                        scan_active_d = 1'b1;
                    end
                endcase
            end else begin
                acc_d         = '0;
                scan_active_d = 1'b0;
                if (mode_rr) begin
                    dm_d    = (state_q == ST_RR) ? dm_q + 2'd1 : 2'd0;
                    state_d = ST_RR;
                end else begin
                    dm_d    = fixed_sel;
                    state_d = ST_FIXED;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q       <= ST_FIXED;
            fc_q          <= '0;
            acc_q         <= '0;
            for (int i = 0; i < 4; i++) e_q[i] <= '0;
            scan_k_q      <= 2'd0;
            hold_q        <= 8'd0;
            dm_q          <= 2'd0;
            sel_changed_q <= 1'b0;
            scan_active_q <= 1'b0;
            best_energy_q <= '0;
        end else begin
            state_q       <= state_d;
            fc_q          <= fc_d;
            acc_q         <= acc_d;
            e_q           <= e_d;
            scan_k_q      <= scan_k_d;
            hold_q        <= hold_d;
            dm_q          <= dm_d;
            sel_changed_q <= (dm_d != dm_q);
            scan_active_q <= scan_active_d;
            best_energy_q <= best_energy_d;
        end
    end

    assign DesiredDM   = dm_q;
    assign sel_changed = sel_changed_q;
    assign scan_active = scan_active_q;
    assign best_energy = best_energy_q;

endmodule
